// File: rtl/ic_trace_pkg.sv
// Shared types and constants for the IceCream-style trace capture stage.
package ic_trace_pkg;

  localparam int IC_DEPTH      = 16;
  localparam int IC_DATA_W     = 32;
  localparam int IC_TAG_W      = 8;
  localparam int IC_TS_W       = 32;
  localparam int IC_FMT_W      = 3;
  localparam int IC_DROP_CNT_W = 16;

  typedef enum logic [IC_FMT_W-1:0] {
    IC_FMT_HEX  = 3'd0,
    IC_FMT_DEC  = 3'd1,
    IC_FMT_CHAR = 3'd2,
    IC_FMT_STR  = 3'd3,
    IC_FMT_ARR  = 3'd4,
    IC_FMT_DROP = 3'd7
  } ic_fmt_e;

  typedef struct packed {
    logic [IC_TS_W-1:0]   ts;
    logic [IC_TAG_W-1:0]  tag;
    ic_fmt_e              fmt;
    logic [IC_DATA_W-1:0] data;
  } ic_trace_rec_t;

  localparam logic [IC_TAG_W-1:0] IC_TAG_DROP = {IC_TAG_W{1'b1}};

  // Drop counter holds at all-ones rather than wrapping back to a misleading small count.
  function automatic logic [IC_DROP_CNT_W-1:0] ic_sat_inc(input logic [IC_DROP_CNT_W-1:0] v);
    logic [IC_DROP_CNT_W-1:0] r;
    if (v == {IC_DROP_CNT_W{1'b1}}) begin
      r = v;
    end else begin
      r = v + {{(IC_DROP_CNT_W-1){1'b0}}, 1'b1};
    end
    return r;
  endfunction

endpackage

// File: rtl/ic_trace_if.sv
// Capture/record bus between a probe source/consumer (master) and the capture stage (slave).
interface ic_trace_if #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 32,
  parameter int TAG_W  = 8,
  parameter int TS_W   = 32
);
  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic              en;
  logic              cap_valid;
  logic [TAG_W-1:0]  cap_tag;
  logic [2:0]        cap_fmt;
  logic [DATA_W-1:0] cap_data;
  logic              rec_valid;
  logic              rec_ready;
  logic [TS_W-1:0]   rec_ts;
  logic [TAG_W-1:0]  rec_tag;
  logic [2:0]        rec_fmt;
  logic [DATA_W-1:0] rec_data;
  logic [LVL_W-1:0]  level;
  logic              ovf;

  modport master (
    output en, cap_valid, cap_tag, cap_fmt, cap_data, rec_ready,
    input  rec_valid, rec_ts, rec_tag, rec_fmt, rec_data, level, ovf
  );

  modport slave (
    input  en, cap_valid, cap_tag, cap_fmt, cap_data, rec_ready,
    output rec_valid, rec_ts, rec_tag, rec_fmt, rec_data, level, ovf
  );

endinterface

// File: rtl/ic_trace_fifo.sv
// Generic synchronous FIFO; pointers carry an extra wrap bit so full/empty/level need no counter.
module ic_trace_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  logic [WIDTH-1:0]           i_wdata,
  output logic [WIDTH-1:0]           o_rdata,
  output logic                       o_empty,
  output logic                       o_full,
  output logic [$clog2(DEPTH):0]     o_level
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             w_empty;
  logic             w_full;
  logic             w_do_push;
  logic             w_do_pop;

  always_comb begin
    w_empty   = (r_wr_ptr == r_rd_ptr);
    w_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    w_do_pop  = i_pop && !w_empty;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept a push.
    w_do_push = i_push && (!w_full || w_do_pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
        r_wr_ptr                <= r_wr_ptr + {{AW{1'b0}}, 1'b1};
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + {{AW{1'b0}}, 1'b1};
      end
    end
  end

  assign o_rdata = r_mem[r_rd_ptr[AW-1:0]];
  assign o_empty = w_empty;
  assign o_full  = w_full;
  assign o_level = r_wr_ptr - r_rd_ptr;

endmodule

// File: rtl/ic_trace_capture.sv
// Timestamped probe-event capture with FIFO drain; lost events set a sticky ovf.
// Optional IC_TRACE_DROP_MARK_EN: counts losses and injects a DROP marker record once space frees.
module ic_trace_capture
  import ic_trace_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 32,
  parameter int TAG_W  = 8,
  parameter int TS_W   = 32
) (
  input  logic       clk,
  input  logic       rst,
  ic_trace_if.slave  bus
);
  localparam int LVL_W = $clog2(DEPTH) + 1;
  localparam int REC_W = TS_W + TAG_W + IC_FMT_W + DATA_W;
  localparam logic [TS_W-1:0] TS_ONE = {{(TS_W-1){1'b0}}, 1'b1};

  logic [TS_W-1:0]  r_ts;
  logic             r_ovf;
  logic [REC_W-1:0] w_wdata;
  logic [REC_W-1:0] w_rdata;
  logic [LVL_W-1:0] w_level;
  logic             w_empty;
  logic             w_full;
  logic             w_pop;
  logic             w_space;
  logic             w_event;
  logic             w_push;
  logic             w_lost;

`ifdef IC_TRACE_DROP_MARK_EN
  localparam logic [TAG_W-1:0] TAG_DROP = {TAG_W{1'b1}};
  logic [IC_DROP_CNT_W-1:0] r_drop_cnt;
  logic                     w_mark;
`endif

  // Push arbitration: a pending drop marker outranks a capture in the same cycle.
  always_comb begin
    w_pop   = !w_empty && bus.rec_ready;
    w_space = !w_full || w_pop;
    w_event = bus.en && bus.cap_valid;
    w_push  = 1'b0;
    w_lost  = 1'b0;
    w_wdata = {r_ts, bus.cap_tag, bus.cap_fmt, bus.cap_data};
`ifdef IC_TRACE_DROP_MARK_EN
    w_mark  = 1'b0;
    if (w_space && (r_drop_cnt != {IC_DROP_CNT_W{1'b0}})) begin
      w_mark  = 1'b1;
      w_push  = 1'b1;
      w_lost  = w_event;
      w_wdata = {r_ts, TAG_DROP, IC_FMT_DROP, {{(DATA_W-IC_DROP_CNT_W){1'b0}}, r_drop_cnt}};
    end else if (w_event) begin
      w_push = w_space;
      w_lost = !w_space;
    end else begin
      w_push = 1'b0;
    end
`else
    if (w_event) begin
      w_push = w_space;
      w_lost = !w_space;
    end else begin
      w_push = 1'b0;
    end
`endif
  end

  // Free-running timestamp, independent of capture enable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ts <= '0;
    end else begin
      r_ts <= r_ts + TS_ONE;
    end
  end

  // Sticky overflow flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if (w_lost) begin
      r_ovf <= 1'b1;
    end else begin
      r_ovf <= r_ovf;
    end
  end

`ifdef IC_TRACE_DROP_MARK_EN
  // Lost-event counter; a capture pre-empted by the marker becomes the first loss of the next run.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_drop_cnt <= '0;
    end else if (w_mark) begin
      r_drop_cnt <= w_lost ? {{(IC_DROP_CNT_W-1){1'b0}}, 1'b1} : {IC_DROP_CNT_W{1'b0}};
    end else if (w_lost) begin
      r_drop_cnt <= ic_sat_inc(r_drop_cnt);
    end else begin
      r_drop_cnt <= r_drop_cnt;
    end
  end
`endif

  ic_trace_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (REC_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_wdata (w_wdata),
    .o_rdata (w_rdata),
    .o_empty (w_empty),
    .o_full  (w_full),
    .o_level (w_level)
  );

  assign bus.rec_valid = !w_empty;
  assign {bus.rec_ts, bus.rec_tag, bus.rec_fmt, bus.rec_data} = w_rdata;
  assign bus.level     = w_level;
  assign bus.ovf       = r_ovf;

endmodule

// File: tb/tb_ic_trace_capture.sv
// Scoreboard bench for ic_trace_capture; a second small-TS_W instance exercises timestamp wrap.
module tb_ic_trace_capture;
  import ic_trace_pkg::*;

  localparam int D = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ic_trace_if #(.DEPTH(D), .DATA_W(32), .TAG_W(8), .TS_W(32)) bus ();
  ic_trace_if #(.DEPTH(4), .DATA_W(32), .TAG_W(4), .TS_W(8))  bus_w ();

  ic_trace_capture #(.DEPTH(D), .DATA_W(32), .TAG_W(8), .TS_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  ic_trace_capture #(.DEPTH(4), .DATA_W(32), .TAG_W(4), .TS_W(8)) dut_wrap (
    .clk (clk),
    .rst (rst),
    .bus (bus_w)
  );

  int             n_tests = 0;
  int             n_fail  = 0;
  ic_trace_rec_t  sb_q[$];
  logic [7:0]     sb_w[$];
  logic [31:0]    m_ts;
  bit             m_ovf;
  int unsigned    m_cnt;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", tag, obs, exp);
    end
  endtask

  // Compare outputs against the model, advance the model by one clock, then the clock itself.
  task automatic step();
    ic_trace_rec_t e;
    ic_trace_rec_t f;
    bit pop;
    bit space;
    bit ev;
    check_eq("rec_valid", 64'(bus.rec_valid), 64'(sb_q.size() != 0));
    check_eq("level", 64'(bus.level), 64'(sb_q.size()));
    check_eq("ovf", 64'(bus.ovf), 64'(m_ovf));
    if (sb_q.size() != 0) begin
      f = sb_q[0];
      check_eq("rec_ts", 64'(bus.rec_ts), 64'(f.ts));
      check_eq("rec_tag", 64'(bus.rec_tag), 64'(f.tag));
      check_eq("rec_fmt", 64'(bus.rec_fmt), 64'(f.fmt));
      check_eq("rec_data", 64'(bus.rec_data), 64'(f.data));
    end
    pop   = (sb_q.size() != 0) && bus.rec_ready;
    space = (sb_q.size() < D) || pop;
    ev    = bus.en && bus.cap_valid;
    if (pop) void'(sb_q.pop_front());
    e.ts   = m_ts;
    e.tag  = bus.cap_tag;
    e.fmt  = ic_fmt_e'(bus.cap_fmt);
    e.data = bus.cap_data;
`ifdef IC_TRACE_DROP_MARK_EN
    if (space && m_cnt != 0) begin
      f.ts   = m_ts;
      f.tag  = IC_TAG_DROP;
      f.fmt  = IC_FMT_DROP;
      f.data = 32'(m_cnt);
      sb_q.push_back(f);
      if (ev) begin
        m_ovf = 1'b1;
        m_cnt = 1;
      end else begin
        m_cnt = 0;
      end
    end else
`endif
    if (ev && space) begin
      sb_q.push_back(e);
    end else if (ev) begin
      m_ovf = 1'b1;
      if (m_cnt < 65535) m_cnt++;
    end
    @(posedge clk);
    #1;
    m_ts = m_ts + 32'd1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    check_eq("rst_rec_valid", 64'(bus.rec_valid), 64'd0);
    check_eq("rst_level", 64'(bus.level), 64'd0);
    check_eq("rst_ovf", 64'(bus.ovf), 64'd0);
    check_eq("rst_rec_ts", 64'(bus.rec_ts), 64'd0);
    check_eq("rst_rec_data", 64'(bus.rec_data), 64'd0);
    sb_q.delete();
    m_ts  = 32'd0;
    m_ovf = 1'b0;
    m_cnt = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic drive_event(input logic [7:0] tag, input logic [2:0] fmt, input logic [31:0] data);
    bus.cap_valid = 1'b1;
    bus.cap_tag   = tag;
    bus.cap_fmt   = fmt;
    bus.cap_data  = data;
    step();
    bus.cap_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    bus.en = 1'b1;      bus.cap_valid = 1'b0; bus.cap_tag = 8'd0;
    bus.cap_fmt = 3'd0; bus.cap_data = 32'd0; bus.rec_ready = 1'b0;
    bus_w.en = 1'b0;    bus_w.cap_valid = 1'b0; bus_w.cap_tag = 4'd0;
    bus_w.cap_fmt = 3'd0; bus_w.cap_data = 32'd0; bus_w.rec_ready = 1'b0;
    do_reset();

    // Single event at ts=5, consumer ready.
    bus.rec_ready = 1'b1;
    idle(5);
    check_eq("t1_ts_model", 64'(bus.rec_ts), 64'd0);
    drive_event(8'd3, 3'(IC_FMT_HEX), 32'h0000_00AB);
    idle(2);

    // Fill to DEPTH, one more is dropped, then drain in order.
    bus.rec_ready = 1'b0;
    for (int i = 0; i < D + 1; i++) drive_event(8'(i), 3'(i % 5), 32'hC0DE_0000 + 32'(i));
    bus.rec_ready = 1'b1;
    idle(D + 4);

    // Full FIFO with simultaneous push and pop: no drops.
    do_reset();
    bus.rec_ready = 1'b0;
    for (int i = 0; i < D; i++) drive_event(8'(i + 32), 3'(IC_FMT_DEC), 32'h1000 + 32'(i));
    bus.rec_ready = 1'b1;
    for (int i = 0; i < 10; i++) drive_event(8'(i + 64), 3'(IC_FMT_CHAR), 32'h2000 + 32'(i));
    idle(D + 2);

    // Fill then lose three events; with markers enabled a DROP record follows the 16.
    bus.rec_ready = 1'b0;
    for (int i = 0; i < D + 3; i++) drive_event(8'(i + 96), 3'(IC_FMT_STR), 32'h3000 + 32'(i));
    bus.rec_ready = 1'b1;
    idle(D + 4);

    // Capture disabled: events ignored and not counted as drops.
    bus.en = 1'b0;
    for (int i = 0; i < 3; i++) drive_event(8'h55, 3'(IC_FMT_ARR), 32'hDEAD);
    bus.en = 1'b1;
    idle(1);

    // Asynchronous reset mid-drain with level 7.
    bus.rec_ready = 1'b0;
    for (int i = 0; i < 10; i++) drive_event(8'(i + 128), 3'(IC_FMT_HEX), 32'h4000 + 32'(i));
    bus.rec_ready = 1'b1;
    idle(3);
    bus.rec_ready = 1'b0;
    check_eq("t6_level_before", 64'(bus.level), 64'd7);
    do_reset();
    bus.rec_ready = 1'b1;
    idle(2);
    drive_event(8'd9, 3'(IC_FMT_DEC), 32'd1234);
    idle(2);

    // Timestamp wrap on the narrow-TS instance: FE, FF, 00.
    for (int i = 0; i < 400 && m_ts != 32'd254; i++) step();
    check_eq("t5_reach_ts", 64'(m_ts), 64'd254);
    bus_w.en = 1'b1;
    bus_w.cap_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus_w.cap_data = 32'(i);
      sb_w.push_back(m_ts[7:0]);
      step();
    end
    bus_w.cap_valid = 1'b0;
    bus_w.rec_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check_eq("wrap_rec_valid", 64'(bus_w.rec_valid), 64'd1);
      check_eq("wrap_rec_data", 64'(bus_w.rec_data), 64'(i));
      check_eq("wrap_rec_ts", 64'(bus_w.rec_ts), 64'(sb_w.pop_front()));
      step();
    end
    check_eq("wrap_level_end", 64'(bus_w.level), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
